// File: rtl/i2c_slave_regfile.sv
// I2C target answering one 7-bit address and exposing a bank of byte registers.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample filter on SCL/SDA.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h3C,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     SCL,
    input  logic                     sdaIn,
    output logic                     sdaDriven,
    input  logic [REG_ADDR_BITS-1:0] localAddr,
    output logic [7:0]               localData,
    output logic                     writeStrobe,
    output logic [REG_ADDR_BITS-1:0] writeReg,
    output logic [7:0]               writeData,
    output logic                     busy
);

    localparam int DEPTH = 2 ** REG_ADDR_BITS;
    localparam logic [REG_ADDR_BITS-1:0] PTR_ONE = REG_ADDR_BITS'(1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, REG, WDATA, ACK_BYTE, RDATA, RACK
    } stateType;

    stateType state, stateNext;
    logic [1:0] sclSync, sdaSync;
    logic busScl, busSda, sclPrev, sdaPrev;
    logic sclRise, sclFall, startCond, stopCond;
    logic [3:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftNext, txByte, txNext, rxByte;
    logic [REG_ADDR_BITS-1:0] pointer, pointerNext, ptrInc;
    logic [REG_ADDR_BITS-1:0] writeRegNext;
    logic [7:0] writeDataNext, curReg, incReg;
    logic rw, rwNext, ackPhase, ackPhaseNext;
    logic sdaDrivenNext, busyNext, strobeNext, regWe;
    logic [7:0] regs [DEPTH];

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clock) begin
        if (reset) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], SCL};
            sdaSync <= {sdaSync[0], sdaIn};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] sclHist, sdaHist;
    logic sclFilt, sdaFilt;

    // Output follows input only after three identical samples
    always_ff @(posedge clock) begin
        if (reset) begin
            sclHist <= 3'b111;
            sdaHist <= 3'b111;
            sclFilt <= 1'b1;
            sdaFilt <= 1'b1;
        end else begin
            sclHist <= {sclHist[1:0], sclSync[1]};
            sdaHist <= {sdaHist[1:0], sdaSync[1]};
            if (&sclHist) sclFilt <= 1'b1;
            else if (~|sclHist) sclFilt <= 1'b0;
            if (&sdaHist) sdaFilt <= 1'b1;
            else if (~|sdaHist) sdaFilt <= 1'b0;
        end
    end

    assign busScl = sclFilt;
    assign busSda = sdaFilt;
`else
    assign busScl = sclSync[1];
    assign busSda = sdaSync[1];
`endif

    // Previous bus levels for edge and condition detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= busScl;
            sdaPrev <= busSda;
        end
    end

    assign sclRise   = busScl & ~sclPrev;
    assign sclFall   = ~busScl & sclPrev;
    assign startCond = sclPrev & busScl & sdaPrev & ~busSda;
    assign stopCond  = sclPrev & busScl & ~sdaPrev & busSda;
    assign rxByte    = {shiftReg[6:0], busSda};
    assign ptrInc    = pointer + PTR_ONE;
    assign curReg    = regs[pointer];
    assign incReg    = regs[ptrInc];
    assign localData = regs[localAddr];

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bitCnt      <= '0;
            shiftReg    <= '0;
            txByte      <= '0;
            pointer     <= '0;
            rw          <= 1'b0;
            ackPhase    <= 1'b0;
            sdaDriven   <= 1'b0;
            busy        <= 1'b0;
            writeStrobe <= 1'b0;
            writeReg    <= '0;
            writeData   <= '0;
        end else begin
            state       <= stateNext;
            bitCnt      <= bitCntNext;
            shiftReg    <= shiftNext;
            txByte      <= txNext;
            pointer     <= pointerNext;
            rw          <= rwNext;
            ackPhase    <= ackPhaseNext;
            sdaDriven   <= sdaDrivenNext;
            busy        <= busyNext;
            writeStrobe <= strobeNext;
            writeReg    <= writeRegNext;
            writeData   <= writeDataNext;
        end
    end

    // Register bank, cleared by reset, written by bus data bytes
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (regWe) begin
            regs[pointer] <= rxByte;
        end
    end

    // Protocol sequencing; START/STOP override every state
    always_comb begin
        stateNext     = state;
        bitCntNext    = bitCnt;
        shiftNext     = shiftReg;
        txNext        = txByte;
        pointerNext   = pointer;
        rwNext        = rw;
        ackPhaseNext  = ackPhase;
        sdaDrivenNext = sdaDriven;
        busyNext      = busy;
        strobeNext    = 1'b0;
        writeRegNext  = writeReg;
        writeDataNext = writeData;
        regWe         = 1'b0;
        if (startCond || stopCond) begin
            stateNext     = startCond ? ADDR : IDLE;
            bitCntNext    = '0;
            ackPhaseNext  = 1'b0;
            sdaDrivenNext = 1'b0;
            busyNext      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                ADDR: if (sclRise) begin
                    shiftNext  = rxByte;
                    bitCntNext = bitCnt + 4'd1;
                    if (bitCnt == 4'd7) begin
                        bitCntNext = '0;
                        if (rxByte[7:1] == SLAVE_ADDRESS) begin
                            stateNext = ACK_ADDR;
                            busyNext  = 1'b1;
                            rwNext    = rxByte[0];
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
                ACK_ADDR: if (sclFall) begin
                    if (!ackPhase) begin
                        sdaDrivenNext = 1'b1;
                        ackPhaseNext  = 1'b1;
                    end else if (rw) begin
                        ackPhaseNext  = 1'b0;
                        stateNext     = RDATA;
                        sdaDrivenNext = ~curReg[7];
                        txNext        = {curReg[6:0], 1'b0};
                        bitCntNext    = 4'd1;
                    end else begin
                        ackPhaseNext  = 1'b0;
                        stateNext     = REG;
                        sdaDrivenNext = 1'b0;
                        bitCntNext    = '0;
                    end
                end
                REG: if (sclRise) begin
                    shiftNext  = rxByte;
                    bitCntNext = bitCnt + 4'd1;
                    if (bitCnt == 4'd7) begin
                        pointerNext = rxByte[REG_ADDR_BITS-1:0];
                        stateNext   = ACK_BYTE;
                        bitCntNext  = '0;
                    end
                end
                WDATA: if (sclRise) begin
                    shiftNext  = rxByte;
                    bitCntNext = bitCnt + 4'd1;
                    if (bitCnt == 4'd7) begin
                        regWe         = 1'b1;
                        strobeNext    = 1'b1;
                        writeRegNext  = pointer;
                        writeDataNext = rxByte;
                        pointerNext   = ptrInc;
                        stateNext     = ACK_BYTE;
                        bitCntNext    = '0;
                    end
                end
                ACK_BYTE: if (sclFall) begin
                    if (!ackPhase) begin
                        sdaDrivenNext = 1'b1;
                        ackPhaseNext  = 1'b1;
                    end else begin
                        ackPhaseNext  = 1'b0;
                        sdaDrivenNext = 1'b0;
                        stateNext     = WDATA;
                        bitCntNext    = '0;
                    end
                end
                RDATA: if (sclFall) begin
                    if (bitCnt == 4'd8) begin
                        sdaDrivenNext = 1'b0;
                        stateNext     = RACK;
                        bitCntNext    = '0;
                    end else begin
                        sdaDrivenNext = ~txByte[7];
                        txNext        = {txByte[6:0], 1'b0};
                        bitCntNext    = bitCnt + 4'd1;
                    end
                end
                RACK: if (sclRise) begin
                    if (!busSda) begin
                        pointerNext = ptrInc;
                        txNext      = incReg;
                        stateNext   = RDATA;
                        bitCntNext  = '0;
                    end else begin
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bus master tasks plus a register-bank model.
// Random and directed transactions are checked against the model.
module tb_i2c_slave_regfile;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic sdaM = 1'b1;
    wire sdaLine;
    logic sdaDriven;
    logic [3:0] localAddr = '0;
    logic [7:0] localData;
    logic writeStrobe;
    logic [3:0] writeReg;
    logic [7:0] writeData;
    logic busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] model [16];
    logic [3:0] mPtr = '0;
    logic [11:0] obsQ[$];
    logic [11:0] expQ[$];
    logic [7:0] payload[$];
    logic drivenSeen = 1'b0;
    logic busySeen = 1'b0;

    assign sdaLine = sdaM & ~sdaDriven;

    i2c_slave_regfile dut (
        .clock(clock),
        .reset(reset),
        .SCL(scl),
        .sdaIn(sdaLine),
        .sdaDriven(sdaDriven),
        .localAddr(localAddr),
        .localData(localData),
        .writeStrobe(writeStrobe),
        .writeReg(writeReg),
        .writeData(writeData),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Capture write notifications and activity flags away from the edge
    always @(negedge clock) begin
        if (writeStrobe) obsQ.push_back({writeReg, writeData});
        if (sdaDriven) drivenSeen = 1'b1;
        if (busy) busySeen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; quarter();
        scl = 1'b1;  quarter();
        sdaM = 1'b0; quarter();
        scl = 1'b0;  quarter();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; quarter();
        scl = 1'b1;  quarter();
        sdaM = 1'b1; quarter();
        quarter();
    endtask

    task automatic sendBit(input logic b, input bit glitch, output logic seen);
        sdaM = b; quarter();
        scl = 1'b1;
        if (glitch) begin
            repeat (4) @(posedge clock);
            #1 sdaM = 1'b1;
            @(posedge clock);
            #1 sdaM = b;
            repeat (3) @(posedge clock);
            #1;
        end else begin
            quarter();
        end
        seen = sdaLine;
        quarter();
        scl = 1'b0; quarter();
    endtask

    task automatic writeByte(input logic [7:0] b, input int glitchBit,
                             output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) sendBit(b[i], (7 - i) == glitchBit, s);
        sendBit(1'b1, 1'b0, s);
        acked = ~s;
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, 1'b0, s);
            d[i] = s;
        end
        sendBit(~masterAck, 1'b0, s);
    endtask

    task automatic compareStrobes();
        int n;
        checkEq("strobeCount", obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkEq("strobe", obsQ[i], expQ[i]);
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic checkLocal(input logic [3:0] a);
        localAddr = a;
        #1;
        checkEq("localData", localData, model[a]);
    endtask

    task automatic txWrite(input logic [6:0] addr, input logic [7:0] regB);
        logic ack;
        logic match;
        match = (addr == 7'h3C);
        i2cStart();
        writeByte({addr, 1'b0}, -1, ack);
        checkEq("addrAck", ack, match);
        if (match) checkEq("busyAfterAddr", busy, 1'b1);
        writeByte(regB, -1, ack);
        checkEq("regAck", ack, match);
        if (match) mPtr = regB[3:0];
        foreach (payload[k]) begin
            writeByte(payload[k], -1, ack);
            checkEq("dataAck", ack, match);
            if (match) begin
                expQ.push_back({mPtr, payload[k]});
                model[mPtr] = payload[k];
                mPtr = mPtr + 4'd1;
            end
        end
        i2cStop();
        checkEq("busyAfterStop", busy, 1'b0);
        compareStrobes();
    endtask

    task automatic txRead(input logic [7:0] regB, input int n);
        logic ack;
        logic [7:0] d;
        i2cStart();
        writeByte(8'h78, -1, ack);
        checkEq("rdAddrAck", ack, 1'b1);
        writeByte(regB, -1, ack);
        checkEq("rdRegAck", ack, 1'b1);
        mPtr = regB[3:0];
        i2cStart();
        writeByte(8'h79, -1, ack);
        checkEq("rdAddr2Ack", ack, 1'b1);
        for (int k = 0; k < n; k++) begin
            readByte(k < n - 1, d);
            checkEq("readData", d, model[mPtr]);
            if (k < n - 1) mPtr = mPtr + 4'd1;
        end
        checkEq("busyAfterNack", busy, 1'b0);
        i2cStop();
        compareStrobes();
    endtask

    initial begin
        logic ack;
        logic [6:0] badAddr;
        int kind;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (4) @(posedge clock);
        #1;
        checkEq("rstSdaDriven", sdaDriven, 1'b0);
        checkEq("rstBusy", busy, 1'b0);
        checkEq("rstStrobe", writeStrobe, 1'b0);
        checkEq("rstWriteReg", writeReg, 4'h0);
        checkEq("rstWriteData", writeData, 8'h00);
        checkLocal(4'd9);
        reset = 1'b0;
        quarter();

        payload = '{8'hA5, 8'h5A};
        txWrite(7'h3C, 8'h02);
        checkLocal(4'd3);
        checkLocal(4'd2);

        txRead(8'h02, 2);

        payload = '{8'hFF};
        drivenSeen = 1'b0;
        busySeen = 1'b0;
        txWrite(7'h28, 8'h02);
        checkEq("mismatchDriven", drivenSeen, 1'b0);
        checkEq("mismatchBusy", busySeen, 1'b0);

        payload = '{8'h11, 8'h22};
        txWrite(7'h3C, 8'h0F);
        checkLocal(4'd15);
        checkLocal(4'd0);

        i2cStart();
        writeByte(8'h78, -1, ack);
        writeByte(8'h05, -1, ack);
        mPtr = 4'd5;
        writeByte(8'h12, 2, ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        checkEq("glitchAck", ack, 1'b1);
        expQ.push_back({mPtr, 8'h12});
        model[mPtr] = 8'h12;
        mPtr = mPtr + 4'd1;
`else
        checkEq("glitchAck", ack, 1'b0);
`endif
        i2cStop();
        compareStrobes();
        checkLocal(4'd5);

        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 3);
            payload.delete();
            if (kind <= 1) begin
                for (int k = 0; k < $urandom_range(1, 3); k++)
                    payload.push_back(8'($urandom));
                txWrite(7'h3C, 8'($urandom));
                checkLocal(4'($urandom));
            end else if (kind == 2) begin
                txRead(8'($urandom), $urandom_range(1, 3));
            end else begin
                badAddr = 7'($urandom);
                if (badAddr == 7'h3C) badAddr = 7'h3D;
                payload.push_back(8'($urandom));
                drivenSeen = 1'b0;
                txWrite(badAddr, 8'($urandom));
                checkEq("randMismatchDriven", drivenSeen, 1'b0);
            end
        end

        payload = '{8'h00};
        txWrite(7'h3C, 8'h07);
        i2cStart();
        writeByte(8'h78, -1, ack);
        writeByte(8'h07, -1, ack);
        i2cStart();
        writeByte(8'h79, -1, ack);
        checkEq("drivenBeforeReset", sdaDriven, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkEq("resetSdaDriven", sdaDriven, 1'b0);
        checkEq("resetBusy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        mPtr = '0;
        i2cStop();
        obsQ.delete();
        expQ.delete();
        for (int i = 0; i < 16; i++) checkLocal(4'(i));
        txRead(8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
